// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^8) inverse / InvSubBytes engine.
// Holds the AES field constants, the FSM state type, the step counter type
// and the combinational inverse affine helper.
// Configuration macro used by the top: GF_INV_SBOX_AFFINE_EN.
package gf_pkg;

    localparam logic [7:0]  GF_POLY_AES  = 8'h1B;
    localparam logic [7:0]  INV_AFFINE_C = 8'h05;
    localparam int unsigned CALC_STEPS   = 13;
    localparam int unsigned STEP_W       = 4;

    typedef logic [STEP_W-1:0] step_t;

    localparam step_t LAST_STEP = step_t'(CALC_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // AES inverse affine transform: r_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ c_i.
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[3'(i + 2)] ^ b[3'(i + 5)] ^ b[3'(i + 7)] ^ INV_AFFINE_C[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_mul8.sv
// Combinational 8x8 multiplier over GF(2^8) with a configurable reduction
// polynomial (bit 8 implicit).
// Ports:
//   i_a, i_b : operands
//   o_p      : product i_a * i_b mod (x^8 + POLY)
module gf_mul8 #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    // Shift-and-add: add the running multiple of i_a for every set bit of i_b,
    // reducing the multiple after each left shift.
    always_comb begin
        logic [7:0] w_acc;
        logic [7:0] w_sh;
        w_acc = 8'h00;
        w_sh  = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc ^ w_sh;
            end
            w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? POLY : 8'h00);
        end
        o_p = w_acc;
    end

endmodule

// File: rtl/gf_inv_sbox_seq.sv
// Multi-cycle GF(2^8) inverter (a^254) built around one shared multiplier.
// With GF_INV_SBOX_AFFINE_EN defined, the captured byte first passes through
// the AES inverse affine transform, so the result is InvSubBytes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input byte valid       in_ready  : block can accept a byte
//   in_data    : input byte
//   out_valid  : result valid           out_ready : consumer accepts result
//   out_data   : result byte (held while out_valid)
module gf_inv_sbox_seq
    import gf_pkg::*;
#(
    parameter logic [7:0] POLY = GF_POLY_AES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_x;
    logic [7:0] r_acc;
    step_t      r_step;
    logic [7:0] r_out_data;

    logic [7:0] w_pre;
    logic [7:0] w_mul_b;
    logic [7:0] w_prod;
    logic       w_in_ready;
    logic       w_out_valid;

    // Optional pre-transform on the capture path.
`ifdef GF_INV_SBOX_AFFINE_EN
    assign w_pre = inv_affine(in_data);
`else
    assign w_pre = in_data;
`endif

    // Even steps square the accumulator, odd steps multiply by the input.
    assign w_mul_b = r_step[0] ? r_x : r_acc;

    gf_mul8 #(
        .POLY (POLY)
    ) u_mul (
        .i_a (r_acc),
        .i_b (w_mul_b),
        .o_p (w_prod)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (in_valid)              w_state_next = CALC;
            CALC: if (r_step == LAST_STEP)   w_state_next = DONE;
            DONE: if (out_ready)             w_state_next = IDLE;
            default:                         w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            DONE:    w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture, exponentiation chain, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= 8'h00;
            r_acc      <= 8'h00;
            r_step     <= '0;
            r_out_data <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x    <= w_pre;
                        r_acc  <= w_pre;
                        r_step <= '0;
                    end
                end
                CALC: begin
                    r_acc  <= w_prod;
                    r_step <= r_step + step_t'(1);
                    if (r_step == LAST_STEP) begin
                        r_out_data <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_gf_inv_sbox_seq.sv
// Self-checking bench for gf_inv_sbox_seq: known-answer table, exhaustive
// inverse sweep with throughput check, backpressure, reset mid-computation
// and simultaneous consume/offer in DONE. Honours GF_INV_SBOX_AFFINE_EN.
module tb_gf_inv_sbox_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  sb[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t vecs[4];

    gf_inv_sbox_seq #(.POLY(8'h1B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference GF(2^8) arithmetic, AES polynomial.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1B) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    // Inverse by exhaustive search for y with a*y == 1.
    function automatic logic [7:0] m_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (m_mul(a, 8'(y)) == 8'h01) r = 8'(y);
        end
        return r;
    endfunction

    function automatic logic [7:0] m_pre(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] c;
        c = 8'h05;
        r = b;
`ifdef GF_INV_SBOX_AFFINE_EN
        for (int i = 0; i < 8; i++) begin
            r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ c[i];
        end
`else
        r = b ^ (c & 8'h00);
`endif
        return r;
    endfunction

    function automatic logic [7:0] m_expect(input logic [7:0] b);
        return m_inv(m_pre(b));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns the cycle of the accepting edge.
    task automatic send(input logic [7:0] b, output int unsigned acc_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready before send", 32'(in_ready), 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        sb.push_back(m_expect(b));
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
    endtask

    // Ends on a falling edge with out_valid high; lat counts edges since accept.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid) break;
            if (lat >= 40) begin
                check("out_valid timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    // Called on a falling edge with out_valid high; consumes on the next edge.
    task automatic take_result(input string name);
        logic [7:0] exp;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            check(name, 32'(out_data), 32'(exp));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        int          spurious;
        int unsigned a_cyc;
        int unsigned prev_cyc;
        logic [7:0]  held;
        logic [7:0]  exp;

`ifdef GF_INV_SBOX_AFFINE_EN
        vecs[0] = '{din: 8'h63, dout: 8'h00};
        vecs[1] = '{din: 8'h00, dout: 8'h52};
        vecs[2] = '{din: 8'h7C, dout: 8'h01};
        vecs[3] = '{din: 8'hED, dout: 8'h53};
`else
        vecs[0] = '{din: 8'h53, dout: 8'hCA};
        vecs[1] = '{din: 8'h02, dout: 8'h8D};
        vecs[2] = '{din: 8'h01, dout: 8'h01};
        vecs[3] = '{din: 8'h00, dout: 8'h00};
`endif

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'h00);
        rst = 1'b0;

        // Known-answer table.
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].din, a_cyc);
            void'(sb.pop_back());
            sb.push_back(vecs[i].dout);
            wait_valid(lat);
            check($sformatf("table latency %0d", i), 32'(lat), 32'd13);
            take_result($sformatf("table data in=0x%02h", vecs[i].din));
        end

        // Exhaustive sweep, out_ready tied high.
        prev_cyc = 0;
        for (int b = 1; b < 256; b++) begin
            send(8'(b), a_cyc);
            if (b > 1) check($sformatf("spacing in=0x%02h", b), 32'(a_cyc - prev_cyc), 32'd15);
            prev_cyc = a_cyc;
            wait_valid(lat);
            check($sformatf("sweep latency in=0x%02h", b), 32'(lat), 32'd13);
`ifndef GF_INV_SBOX_AFFINE_EN
            check($sformatf("sweep in*out in=0x%02h", b), 32'(m_mul(8'(b), out_data)), 32'h01);
`endif
            take_result($sformatf("sweep data in=0x%02h", b));
        end

        // Backpressure: result held for 20 cycles, input pulse ignored.
        out_ready = 1'b0;
        send(8'h53, a_cyc);
        wait_valid(lat);
        held = out_data;
        check("bp first data", 32'(held), 32'(m_expect(8'h53)));
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) begin
                in_data  = 8'h02;
                in_valid = 1'b1;
            end
            if (k == 6) in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("bp out_valid k=%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp in_ready k=%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("bp out_data k=%0d", k), 32'(out_data), 32'(held));
        end
        take_result("bp data");
        check("bp after in_ready", 32'(in_ready), 32'd1);
        check("bp after out_valid", 32'(out_valid), 32'd0);
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("bp pulse ignored", 32'(spurious), 32'd0);

        // Reset while at step 6 of CALC.
        @(posedge clk);
        #1;
        send(8'h53, a_cyc);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_data", 32'(out_data), 32'h00);
        sb.delete();
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("midrst no result", 32'(spurious), 32'd0);
        @(posedge clk);
        #1;
        send(8'h53, a_cyc);
        wait_valid(lat);
        check("midrst next latency", 32'(lat), 32'd13);
        take_result("midrst next data");

        // out_ready and in_valid together in DONE.
        out_ready = 1'b0;
        send(8'h01, a_cyc);
        wait_valid(lat);
        exp = sb.pop_front();
        check("sim first data", 32'(out_data), 32'(exp));
        in_data   = 8'h02;
        in_valid  = 1'b1;
        sb.push_back(m_expect(8'h02));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("sim consumed out_valid", 32'(out_valid), 32'd0);
        check("sim idle in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sim accepted in_ready", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("sim second latency", 32'(lat), 32'd13);
        take_result("sim second data");

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
